// File: rtl/serial_mult_ctrl.sv
// serial_mult_ctrl
// Sequencer for an unsigned shift-and-add multiplier that time-multiplexes a
// single bit-serial full adder and its carry flop. Each multiplier bit costs
// one WIDTH-cycle ADD pass over the multiplicand, followed by one SHIFT cycle.
// The final SHIFT also loads the product register, so done and product update
// on the same edge.
//
// Optional feature: define MULT_SKIP_ZERO_EN to skip the ADD pass for zero
// multiplier bits. The product is unchanged. Latency becomes data-dependent.

module serial_mult_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      ADD,
      SHIFT,
      DONE
   } state_t;

   state_t state;
   state_t state_next;

   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;
   logic             carry;
   logic [CW-1:0]    bit_cnt;
   logic [CW-1:0]    iter_cnt;

   logic             pp_bit;
   logic             sum_bit;
   logic             carry_next;
   logic [WIDTH-1:0] shift_hi;
   logic [WIDTH-1:0] shift_lo;

   // Full-adder cell plus the one-bit right shift of {carry, acc_hi, acc_lo}
   always_comb begin
      pp_bit     = mcand[0] & mplier[0];
      sum_bit    = acc_hi[0] ^ pp_bit ^ carry;
      carry_next = (acc_hi[0] & pp_bit) | (acc_hi[0] & carry) | (pp_bit & carry);
      shift_hi   = {carry, acc_hi[WIDTH-1:1]};
      shift_lo   = {acc_hi[0], acc_lo[WIDTH-1:1]};
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decision; the optional skip looks at the upcoming multiplier bit
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
`ifdef MULT_SKIP_ZERO_EN
               state_next = multiplier[0] ? ADD : SHIFT;
`else
               state_next = ADD;
`endif
            end
         end
         ADD: begin
            if (bit_cnt == LAST) begin
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            if (iter_cnt == LAST) begin
               state_next = DONE;
            end else begin
`ifdef MULT_SKIP_ZERO_EN
               state_next = mplier[1] ? ADD : SHIFT;
`else
               state_next = ADD;
`endif
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath: operand capture, serial add passes, shifts and product load
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mcand    <= '0;
         mplier   <= '0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         carry    <= 1'b0;
         bit_cnt  <= '0;
         iter_cnt <= '0;
         product  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mcand    <= multiplicand;
                  mplier   <= multiplier;
                  acc_hi   <= '0;
                  acc_lo   <= '0;
                  carry    <= 1'b0;
                  bit_cnt  <= '0;
                  iter_cnt <= '0;
               end
            end
            ADD: begin
               acc_hi  <= {sum_bit, acc_hi[WIDTH-1:1]};
               mcand   <= {mcand[0], mcand[WIDTH-1:1]};
               carry   <= carry_next;
               bit_cnt <= bit_cnt + 1'b1;
            end
            SHIFT: begin
               acc_hi  <= shift_hi;
               acc_lo  <= shift_lo;
               mplier  <= {1'b0, mplier[WIDTH-1:1]};
               carry   <= 1'b0;
               bit_cnt <= '0;
               if (iter_cnt == LAST) begin
                  product <= {shift_hi, shift_lo};
               end else begin
                  iter_cnt <= iter_cnt + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Status outputs decode directly from the state register
   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
   end

endmodule

// File: tb/tb_serial_mult_ctrl.sv
// tb_serial_mult_ctrl
// Self-checking bench for serial_mult_ctrl at WIDTH=8. Expected products come
// from plain multiplication; expected latency comes from the timing rules
// (fixed W*(W+1), or W + popcount(B)*W when MULT_SKIP_ZERO_EN is defined).

module tb_serial_mult_ctrl;

   localparam int W = 8;
   localparam int TIMEOUT = 200;

   logic           clk;
   logic           reset;
   logic           start;
   logic [W-1:0]   multiplicand;
   logic [W-1:0]   multiplier;
   logic           busy;
   logic           done;
   logic [2*W-1:0] product;

   int checks;
   int errors;

   serial_mult_ctrl #(.WIDTH(W)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   // Free-running clock, 10 ns period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int exp_latency(input logic [W-1:0] b);
`ifdef MULT_SKIP_ZERO_EN
      return W + $countones(b) * W;
`else
      return W * (W + 1);
`endif
   endfunction

   function automatic logic [2*W-1:0] exp_product(input logic [W-1:0] a, input logic [W-1:0] b);
      int unsigned p;
      p = int'(a) * int'(b);
      return p[2*W-1:0];
   endfunction

   // Starts one multiply and waits for done; caller must leave the DUT idle
   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                output int cycles, output logic [2*W-1:0] prod,
                                output logic busy_ok, output logic busy_at_done,
                                output logic done_after, output logic busy_after,
                                output logic timed_out);
      multiplicand = a;
      multiplier   = b;
      start        = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
      cycles    = 0;
      busy_ok   = 1'b1;
      timed_out = 1'b0;
      while (done !== 1'b1) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (cycles >= TIMEOUT) begin
            timed_out = 1'b1;
            break;
         end
         @(posedge clk); #1;
         cycles++;
      end
      prod         = product;
      busy_at_done = busy;
      @(posedge clk); #1;
      done_after = done;
      busy_after = busy;
   endtask

   task automatic test_reset();
      reset        = 1'b0;
      start        = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
      checks++;
      if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
      checks++;
      if (product !== '0) begin errors++; $display("[TB] FAIL reset_product got=%0d exp=0", product); end
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int cyc;
      logic [2*W-1:0] p;
      logic bok, bdone, dafter, bafter, to;
      applyStimulus(8'd13, 8'd11, cyc, p, bok, bdone, dafter, bafter, to);
      checks++;
      if (to || p !== 16'd143) begin errors++; $display("[TB] FAIL basic_product got=%0d exp=143 timeout=%b", p, to); end
      checks++;
      if (cyc != exp_latency(8'd11)) begin errors++; $display("[TB] FAIL basic_latency got=%0d exp=%0d", cyc, exp_latency(8'd11)); end
      checks++;
      if (bok !== 1'b1 || bdone !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_high got=%b/%b exp=1/1", bok, bdone); end
      checks++;
      if (dafter !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_pulse got=%b exp=0", dafter); end
      checks++;
      if (bafter !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_fall got=%b exp=0", bafter); end
   endtask

   task automatic test_corners();
      logic [W-1:0] av [6];
      logic [W-1:0] bv [6];
      int cyc;
      logic [2*W-1:0] p;
      logic bok, bdone, dafter, bafter, to;
      av = '{8'd255, 8'd0,   8'd200, 8'd5, 8'd3,   8'd1};
      bv = '{8'd255, 8'd200, 8'd0,   8'd2, 8'd255, 8'd128};
      for (int i = 0; i < 6; i++) begin
         applyStimulus(av[i], bv[i], cyc, p, bok, bdone, dafter, bafter, to);
         checks++;
         if (to || p !== exp_product(av[i], bv[i])) begin
            errors++;
            $display("[TB] FAIL corner_product %0d*%0d got=%0d exp=%0d", av[i], bv[i], p, exp_product(av[i], bv[i]));
         end
         checks++;
         if (cyc != exp_latency(bv[i])) begin
            errors++;
            $display("[TB] FAIL corner_latency %0d*%0d got=%0d exp=%0d", av[i], bv[i], cyc, exp_latency(bv[i]));
         end
      end
   endtask

   task automatic test_ignore_start();
      int cyc;
      multiplicand = 8'd13;
      multiplier   = 8'd11;
      start        = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc   = 0;
      while (done !== 1'b1 && cyc < TIMEOUT) begin
         if (cyc == 4) begin
            multiplicand = 8'd1;
            multiplier   = 8'd1;
            start        = 1'b1;
         end
         if (cyc == 10) start = 1'b0;
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      checks++;
      if (product !== 16'd143) begin errors++; $display("[TB] FAIL ignore_start_product got=%0d exp=143", product); end
      checks++;
      if (cyc != exp_latency(8'd11)) begin errors++; $display("[TB] FAIL ignore_start_latency got=%0d exp=%0d", cyc, exp_latency(8'd11)); end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ignore_start_no_restart got=%b exp=0", busy); end
   endtask

   task automatic test_reset_mid();
      int cyc;
      logic [2*W-1:0] p;
      logic bok, bdone, dafter, bafter, to;
      multiplicand = 8'd13;
      multiplier   = 8'd11;
      start        = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (29) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
         errors++;
         $display("[TB] FAIL reset_mid_clear got busy=%b done=%b product=%0d exp 0/0/0", busy, done, product);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      applyStimulus(8'd7, 8'd9, cyc, p, bok, bdone, dafter, bafter, to);
      checks++;
      if (to || p !== 16'd63) begin errors++; $display("[TB] FAIL reset_mid_product got=%0d exp=63", p); end
      checks++;
      if (cyc != exp_latency(8'd9)) begin errors++; $display("[TB] FAIL reset_mid_latency got=%0d exp=%0d", cyc, exp_latency(8'd9)); end
   endtask

   task automatic test_random();
      logic [W-1:0] a, b;
      int cyc;
      logic [2*W-1:0] p;
      logic bok, bdone, dafter, bafter, to;
      for (int i = 0; i < 20; i++) begin
         a = W'($urandom_range(0, 255));
         b = W'($urandom_range(0, 255));
         applyStimulus(a, b, cyc, p, bok, bdone, dafter, bafter, to);
         checks++;
         if (to || p !== exp_product(a, b)) begin
            errors++;
            $display("[TB] FAIL random_product %0d*%0d got=%0d exp=%0d", a, b, p, exp_product(a, b));
         end
         checks++;
         if (cyc != exp_latency(b) || dafter !== 1'b0 || bafter !== 1'b0) begin
            errors++;
            $display("[TB] FAIL random_timing %0d*%0d got=%0d/%b/%b exp=%0d/0/0", a, b, cyc, dafter, bafter, exp_latency(b));
         end
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      multiplicand = 8'd21;
      multiplier   = 8'd6;
      start        = 1'b1;
      @(posedge clk); #1;
      cyc = 0;
      while (done !== 1'b1 && cyc < TIMEOUT) begin
         @(posedge clk); #1;
         cyc++;
      end
      checks++;
      if (product !== 16'd126) begin errors++; $display("[TB] FAIL b2b_first_product got=%0d exp=126", product); end
      multiplicand = 8'd99;
      multiplier   = 8'd77;
      cyc = 0;
      @(posedge clk); #1;
      cyc++;
      while (done !== 1'b1 && cyc < TIMEOUT) begin
         if (cyc == 3) start = 1'b0;
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      checks++;
      if (product !== 16'd7623) begin errors++; $display("[TB] FAIL b2b_second_product got=%0d exp=7623", product); end
      checks++;
      if (cyc != 2 + exp_latency(8'd77)) begin errors++; $display("[TB] FAIL b2b_gap got=%0d exp=%0d", cyc, 2 + exp_latency(8'd77)); end
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Scenario sequence
   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_corners();
      test_ignore_start();
      test_reset_mid();
      test_random();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
